// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP slice through an N-tap multiply-accumulate,
// tracking accepted operand pairs through the multiplier pipeline with tags.
module dsp_mac_sequencer #(
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             bias_en,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ceab,
    output logic             cep,
    output logic [7:0]       op_mode,
    output logic             result_valid,
    output logic [CNT_W-1:0] cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] len_q;
    logic bias_q;
    // tag = {valid, first, last}; entry PIPE_LAT-1 lines up with the M output
    logic [2:0] pipe [PIPE_LAT];
    logic [2:0] tag_in, tag_out;
    logic is_last;
    assign tag_out = pipe[PIPE_LAT-1];
    assign is_last = cnt == len_q - CNT_W'(1);
    assign busy    = state != IDLE;
    assign ceab    = in_valid && in_ready;
    assign tag_in  = ceab ? {1'b1, cnt == '0, is_last} : 3'b000;
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        cep          = 1'b0;
        op_mode      = 8'h00;
        result_valid = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = (len == '0) ? DONE : RUN;
                cep       = len == '0;
                op_mode   = (len == '0 && bias_en) ? 8'h0C : 8'h00;
            end
            RUN, DRAIN: begin
                in_ready = state == RUN && cnt < len_q;
                cep      = tag_out[2];
                op_mode  = (tag_out[2] && tag_out[1]) ? (bias_q ? 8'h0D : 8'h01) : 8'h09;
                if (state == RUN && in_valid && cnt < len_q && is_last)
                    state_nxt = DRAIN;
                if (state == DRAIN && tag_out[2] && tag_out[0])
                    state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            cep       = 1'b0;
            in_ready  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= '0;
            bias_q <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= 3'b000;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                len_q  <= len;
                bias_q <= bias_en;
                cnt    <= '0;
            end else if (ceab) begin
                cnt <= cnt + CNT_W'(1);
            end
            for (int i = PIPE_LAT - 1; i > 0; i--) pipe[i] <= abort ? 3'b000 : pipe[i-1];
            pipe[0] <= abort ? 3'b000 : tag_in;
        end
    end
endmodule
